// File: rtl/hack_screen_scanout_if.sv
// Screen-RAM read port used by the Hack scan-out stage.
// The scan-out side is the master (issues requests), the RAM side is the slave.
interface hack_screen_scanout_if;
  logic        rd_req;    // request, held until rd_ack
  logic [12:0] rd_addr;   // {row[7:0], group[4:0]}, stable while rd_req is high
  logic        rd_ack;    // request accepted this cycle
  logic [15:0] rd_data;   // read data, qualified by rd_valid
  logic        rd_valid;  // one-cycle data strobe, at most one per accepted request

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/hack_screen_scanout.sv
// Hack screen scan-out stage.
// Prefetches one 16-bit screen word per 16 pixels from the 8K x 16 screen RAM,
// serialises it LSB-first (bit 0 = leftmost pixel) and drives a registered
// 3-bit colour. The 512x256 image sits at (X0, Y0) inside the 640x480 frame;
// everything else is border colour. A word that is not back by its group
// boundary kills the rest of the line, which is then shown in ERR colour.
module hack_screen_scanout #(
  parameter logic [9:0] X0  = 10'd64,   // first window column, multiple of 16, >= 16
  parameter logic [9:0] Y0  = 10'd112,  // first window row
  parameter logic [2:0] FG  = 3'b111,   // colour for screen bit = 1
  parameter logic [2:0] BG  = 3'b000,   // colour for screen bit = 0 and border
  parameter logic [2:0] ERR = 3'b100    // colour for pixels lost to an underrun
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [9:0]                   CounterX,
  input  logic [9:0]                   CounterY,
  input  logic                         inDisplayArea,
  hack_screen_scanout_if.master        rd,
  output logic [2:0]                   pixel,
  output logic                         underrun
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // no word pending
    ST_REQ  = 3'd1,  // rd_req high, waiting for rd_ack
    ST_WAIT = 3'd2,  // accepted, waiting for rd_valid
    ST_FULL = 3'd3,  // word_buf_r holds the next word
    ST_DEAD = 3'd4   // rest of line lost, draining any outstanding read
  } state_t;

  // The first word of a row is requested one group ahead of the window.
  localparam logic [9:0] FETCH_X = X0 - 10'd16;
  localparam logic [9:0] WIN_W   = 10'd512;
  localparam logic [9:0] WIN_H   = 10'd256;

  // State and datapath registers
  state_t      state_r;
  state_t      state_n;
  logic        pend_r;       // accepted read whose data has not come back yet
  logic        pend_n;
  logic [15:0] word_buf_r;   // next word
  logic [15:0] shreg_r;      // word currently being displayed
  logic        show_r;       // current group holds fetched data
  logic        show_n;
  logic        line_err_r;   // an underrun already happened on this line
  logic        line_err_n;

  // Registered outputs
  logic        rd_req_r;
  logic [12:0] rd_addr_r;
  logic [12:0] addr_n;
  logic [2:0]  pixel_r;
  logic [2:0]  pixel_n;
  logic        underrun_r;
  logic        underrun_n;

  // FSM side effects for this cycle
  logic        load_buf;
  logic        load_shreg;
  logic        ur_evt;

  // Beam position decode
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic        in_row;
  logic        in_col;
  logic        at_fetch;
  logic        at_bound;
  logic        last_group;
  logic [7:0]  row;
  logic [4:0]  group;
  logic [3:0]  bit_idx;
  logic [15:0] cur_word;

  // Map one screen bit to its colour.
  function automatic logic [2:0] bit_colour(input logic b);
    logic [2:0] c;
    if (b) begin
      c = FG;
    end else begin
      c = BG;
    end
    return c;
  endfunction

  // Window geometry of the current beam position.
  always_comb begin
    dx         = CounterX - X0;
    dy         = CounterY - Y0;
    in_row     = (CounterY >= Y0) && (dy < WIN_H);
    in_col     = (CounterX >= X0) && (dx < WIN_W);
    row        = dy[7:0];
    group      = dx[8:4];
    bit_idx    = dx[3:0];
    at_fetch   = in_row && (CounterX == FETCH_X);
    at_bound   = in_row && in_col && (bit_idx == 4'd0);
    last_group = (group == 5'd31);
  end

  // Fetch FSM: next state, next request address and buffer load strobes.
  always_comb begin
    state_n    = state_r;
    pend_n     = pend_r;
    addr_n     = rd_addr_r;
    load_buf   = 1'b0;
    load_shreg = 1'b0;
    ur_evt     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (at_fetch) begin
          state_n = ST_REQ;
          addr_n  = {row, 5'd0};
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (at_bound) begin
          // Underrun: the request is withdrawn, unless it is accepted right now.
          ur_evt  = 1'b1;
          state_n = ST_DEAD;
          pend_n  = rd.rd_ack;
        end else if (rd.rd_ack) begin
          state_n = ST_WAIT;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (at_bound) begin
          // Underrun: data arriving in this very cycle is already too late.
          ur_evt  = 1'b1;
          state_n = ST_DEAD;
          pend_n  = ~rd.rd_valid;
        end else if (rd.rd_valid) begin
          state_n  = ST_FULL;
          load_buf = 1'b1;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_FULL: begin
        if (at_bound) begin
          load_shreg = 1'b1;
          if (last_group) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_REQ;
            addr_n  = {row, group + 5'd1};
          end
        end else begin
          state_n = ST_FULL;
        end
      end
      ST_DEAD: begin
        if (!pend_r) begin
          state_n = ST_IDLE;
        end else if (rd.rd_valid) begin
          // Late data for a killed line is dropped.
          state_n = ST_IDLE;
          pend_n  = 1'b0;
        end else begin
          state_n = ST_DEAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pend_n  = 1'b0;
      end
    endcase
  end

  // Line status: data-valid flag, line error flag and sticky underrun flag.
  always_comb begin
    // At a boundary the group shows data only if its word was ready.
    if (at_bound) begin
      show_n = (state_r == ST_FULL);
    end else begin
      show_n = show_r;
    end
    // The error flag covers the rest of the window columns on this line.
    if (ur_evt) begin
      line_err_n = 1'b1;
    end else if (!in_col) begin
      line_err_n = 1'b0;
    end else begin
      line_err_n = line_err_r;
    end
    // Set wins over the frame-start clear.
    if (ur_evt) begin
      underrun_n = 1'b1;
    end else if ((CounterX == 10'd0) && (CounterY == 10'd0)) begin
      underrun_n = 1'b0;
    end else begin
      underrun_n = underrun_r;
    end
  end

  // Pixel colour for the current beam position.
  always_comb begin
    // The shift register only loads at the boundary edge, so bypass it there.
    if (at_bound) begin
      cur_word = word_buf_r;
    end else begin
      cur_word = shreg_r;
    end
    if (!inDisplayArea || !in_row || !in_col) begin
      pixel_n = BG;
    end else if (line_err_r || ur_evt) begin
      pixel_n = ERR;
    end else if (!show_n) begin
      pixel_n = BG;
    end else begin
      pixel_n = bit_colour(cur_word[bit_idx]);
    end
  end

  // FSM state register and outstanding-read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      pend_r  <= pend_n;
    end
  end

  // Word buffers and per-line display flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf_r <= 16'h0000;
      shreg_r    <= 16'h0000;
      show_r     <= 1'b0;
      line_err_r <= 1'b0;
    end else begin
      if (load_buf) begin
        word_buf_r <= rd.rd_data;
      end else begin
        word_buf_r <= word_buf_r;
      end
      if (load_shreg) begin
        shreg_r <= word_buf_r;
      end else begin
        shreg_r <= shreg_r;
      end
      show_r     <= show_n;
      line_err_r <= line_err_n;
    end
  end

  // Registered outputs: read request/address, pixel colour, underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_r   <= 1'b0;
      rd_addr_r  <= 13'd0;
      pixel_r    <= 3'b000;
      underrun_r <= 1'b0;
    end else begin
      rd_req_r   <= (state_n == ST_REQ);
      rd_addr_r  <= addr_n;
      pixel_r    <= pixel_n;
      underrun_r <= underrun_n;
    end
  end

  assign rd.rd_req  = rd_req_r;
  assign rd.rd_addr = rd_addr_r;
  assign pixel      = pixel_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Self-checking bench for hack_screen_scanout.
// Drives compressed scan lines (CounterX 0..647 per row), emulates the screen
// RAM with per-group ack/data latencies, and checks every pixel, the read
// addresses and the underrun flag against a window/latency reference model.
module tb_hack_screen_scanout;

  localparam int X0       = 64;
  localparam int Y0       = 112;
  localparam int LINE_LEN = 648;
  localparam logic [2:0] FG  = 3'b111;
  localparam logic [2:0] BG  = 3'b000;
  localparam logic [2:0] ERR = 3'b100;

  logic        clk;
  logic        rst_n;
  logic [9:0]  CounterX;
  logic [9:0]  CounterY;
  logic        inDisplayArea;
  logic [2:0]  pixel;
  logic        underrun;

  hack_screen_scanout_if mif ();

  hack_screen_scanout dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CounterX      (CounterX),
    .CounterY      (CounterY),
    .inDisplayArea (inDisplayArea),
    .rd            (mif),
    .pixel         (pixel),
    .underrun      (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen memory image and per-group latency plan of the current line.
  logic [15:0] mem [0:8191];
  int          lat_da [0:31];   // cycles rd_req is held before ack
  int          lat_dv [0:31];   // cycles from ack to rd_valid
  int          rd_log [$];      // accepted read addresses
  int          req_cycles;
  int          err_group;       // first group shown as ERR (32 = none)
  int          rst_x;           // column where reset hits this line (-1 = none)
  logic        ur_exp;
  int          n_total;
  int          n_bad;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lat(input int da, input int dv);
    for (int k = 0; k < 32; k++) begin
      lat_da[k] = da;
      lat_dv[k] = dv;
    end
  endtask

  // Reference pixel for one beam position on the current line.
  function automatic logic [2:0] exp_pix(input int x, input int y, input logic d);
    int g;
    int b;
    logic [15:0] w;
    if (!d) return BG;
    if (y < Y0 || y >= Y0 + 256 || x < X0 || x >= X0 + 512) return BG;
    if (rst_x >= 0 && x >= rst_x) return BG;
    g = (x - X0) / 16;
    b = (x - X0) % 16;
    if (g >= err_group) return ERR;
    w = mem[(y - Y0) * 32 + g];
    return w[b] ? FG : BG;
  endfunction

  // Screen RAM emulation: ack after lat_da cycles, data lat_dv cycles later.
  initial begin : ram_side
    int          age;
    int          v_cnt;
    logic [12:0] v_addr;
    logic [12:0] held;
    age = 0;
    v_cnt = 0;
    v_addr = 13'd0;
    held = 13'd0;
    mif.rd_ack   = 1'b0;
    mif.rd_valid = 1'b0;
    mif.rd_data  = 16'h0000;
    forever begin
      @(negedge clk);
      mif.rd_ack   = 1'b0;
      mif.rd_valid = 1'b0;
      mif.rd_data  = 16'($urandom);
      if (v_cnt > 0) begin
        v_cnt--;
        if (v_cnt == 0) begin
          mif.rd_valid = 1'b1;
          mif.rd_data  = mem[v_addr];
        end
      end
      if (mif.rd_req === 1'b1) begin
        req_cycles++;
        if (age == 0) begin
          held = mif.rd_addr;
        end else begin
          check_val("addr_stable", 32'(mif.rd_addr), 32'(held));
        end
        if (age >= lat_da[held[4:0]]) begin
          mif.rd_ack = 1'b1;
          rd_log.push_back(int'(held));
          v_addr = held;
          v_cnt  = lat_dv[held[4:0]];
          age    = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // One scan line; rst_at >= 0 pulses reset mid-line at that column.
  task automatic run_line(input int y, input bit rand_de, input int rst_at, input bit chk_reads);
    int   px;
    int   py;
    logic pd;
    int   exp_reads;
    bit   win;
    win = (y >= Y0 && y < Y0 + 256);
    err_group = 32;
    exp_reads = 32;
    for (int k = 31; k >= 0; k--) begin
      if (lat_da[k] + lat_dv[k] >= 15) begin
        err_group = k;
        exp_reads = k + ((lat_da[k] <= 15) ? 1 : 0);
      end
    end
    if (!win) exp_reads = 0;
    rst_x = rst_at;
    if (y == 0) ur_exp = 1'b0;
    if (rst_at >= 0) ur_exp = 1'b0;
    else if (win && err_group < 32) ur_exp = 1'b1;
    rd_log.delete();
    req_cycles = 0;
    px = 0;
    py = y;
    pd = 1'b0;
    for (int x = 0; x < LINE_LEN; x++) begin
      @(negedge clk);
      if (x > 0) check_val($sformatf("pix x=%0d y=%0d", px, py), 32'(pixel), 32'(exp_pix(px, py, pd)));
      if (x == LINE_LEN - 1) check_val($sformatf("underrun y=%0d", y), 32'(underrun), 32'(ur_exp));
      CounterX = 10'(x);
      CounterY = 10'(y);
      if (x >= 640) inDisplayArea = 1'b0;
      else if (rand_de) inDisplayArea = ($urandom_range(0, 7) != 0);
      else inDisplayArea = 1'b1;
      px = x;
      pd = inDisplayArea;
      if (x == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_pixel", 32'(pixel), 32'd0);
        check_val("rst_rd_req", 32'(mif.rd_req), 32'd0);
        check_val("rst_underrun", 32'(underrun), 32'd0);
      end
      if (rst_at >= 0 && x == rst_at + 20) rst_n = 1'b1;
    end
    if (chk_reads) begin
      check_val($sformatf("nreads y=%0d", y), 32'(rd_log.size()), 32'(exp_reads));
      for (int i = 0; i < rd_log.size() && i < exp_reads; i++) begin
        check_val($sformatf("rd_addr y=%0d i=%0d", y, i), 32'(rd_log[i]), 32'((y - Y0) * 32 + i));
      end
      if (!win) check_val($sformatf("no_req y=%0d", y), 32'(req_cycles), 32'd0);
    end
  endtask

  initial begin : main
    int y;
    int k;
    n_total = 0;
    n_bad = 0;
    rst_x = -1;
    err_group = 32;
    ur_exp = 1'b0;
    req_cycles = 0;
    rst_n = 1'b0;
    CounterX = 10'd0;
    CounterY = 10'd0;
    inDisplayArea = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    mem[5 * 32 + 7] = 16'hA5C3;
    set_lat(0, 1);

    #1;
    check_val("reset_pixel", 32'(pixel), 32'd0);
    check_val("reset_rd_req", 32'(mif.rd_req), 32'd0);
    check_val("reset_rd_addr", 32'(mif.rd_addr), 32'd0);
    check_val("reset_underrun", 32'(underrun), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed lines
    run_line(0, 1'b0, -1, 1'b1);
    run_line(Y0 - 1, 1'b0, -1, 1'b1);          // border row above
    run_line(Y0, 1'b0, -1, 1'b1);              // zero-wait, word 0x0001 at 0
    run_line(Y0 + 5, 1'b0, -1, 1'b1);          // 0xA5C3 at {5, 7}
    set_lat(5, 3);
    run_line(Y0 + 6, 1'b0, -1, 1'b1);          // back-pressure
    set_lat(0, 1);
    lat_da[10] = 2;
    lat_dv[10] = 25;
    run_line(Y0 + 7, 1'b0, -1, 1'b1);          // late data for group 10
    set_lat(1, 2);
    run_line(Y0 + 8, 1'b0, -1, 1'b1);          // next row normal, flag sticky
    lat_da[20] = 40;
    run_line(Y0 + 9, 1'b0, -1, 1'b1);          // group 20 never acked
    set_lat(0, 1);
    run_line(0, 1'b0, -1, 1'b1);               // frame start clears flag
    run_line(Y0 + 255, 1'b0, -1, 1'b1);
    run_line(Y0 + 256, 1'b0, -1, 1'b1);        // border row below
    lat_dv[3] = 30;
    run_line(Y0 + 19, 1'b0, -1, 1'b1);
    set_lat(0, 1);
    run_line(Y0 + 20, 1'b0, 200, 1'b0);        // reset mid-line
    run_line(Y0 + 21, 1'b0, -1, 1'b1);

    // Randomised lines
    for (int n = 0; n < 16; n++) begin
      for (int g = 0; g < 32; g++) begin
        lat_da[g] = $urandom_range(0, 6);
        lat_dv[g] = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) begin
          lat_da[k] = $urandom_range(0, 4);
          lat_dv[k] = $urandom_range(20, 30);
        end else begin
          lat_da[k] = $urandom_range(20, 40);
        end
      end
      if ($urandom_range(0, 9) == 0) y = 0;
      else y = $urandom_range(Y0 - 4, Y0 + 259);
      run_line(y, ($urandom_range(0, 1) == 1), -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_screen_scanout.md
# hack_screen_scanout

Screen-memory scan-out stage between the Hack screen RAM (8K x 16, 512x256 monochrome) and the VGA pixel pins. Consumes CounterX/CounterY/inDisplayArea from the hvsync generator on the 25 MHz pixel clock. Prefetches one 16-bit screen word per 16 pixels over a request/acknowledge read port, serializes it LSB-first and drives the registered 3-bit pixel bus. The 512x256 image is centred in the 640x480 frame and surrounded by a border colour.

## Interface
- X0, 64: first active column of the Hack window; must be a multiple of 16 and at least 16.
- Y0, 112: first active row of the Hack window.
- FG, 3'b111: colour for screen bit = 1.
- BG, 3'b000: colour for screen bit = 0 and for the border.
- ERR, 3'b100: colour shown for pixels lost to a read underrun.

Ports:
- clk  in  1  pixel clock (clk_25); all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- CounterX  in  10  horizontal count from hvsync generator.
- CounterY  in  10  vertical count from hvsync generator.
- inDisplayArea  in  1  high inside the 640x480 visible area.
- rd_req  out  1  read request; held until rd_ack.
- rd_addr  out  13  word address {row[7:0], group[4:0]}; stable while rd_req is high.
- rd_ack  in  1  request accepted this cycle.
- rd_data  in  16  read data; valid when rd_valid is high.
- rd_valid  in  1  one-cycle data strobe; at most one per accepted request.
- pixel  out  3  registered pixel colour to pix2..pix0.
- underrun  out  1  sticky; set on any underrun, cleared at frame start.

## Operation
- Window: row r = CounterY - Y0 with 0 <= r < 256; group g = (CounterX - X0) >> 4 with 0 <= g < 32. Outside the window, or when inDisplayArea = 0, the pixel register loads BG.
- Datapath: buf (16 b, next word), shreg (16 b, current word), bit index = (CounterX - X0)[3:0]. Inside the window the pixel register loads FG if shreg[index] = 1, otherwise BG; bit 0 is the leftmost pixel.
- FSM states:
  - IDLE: no word pending.
  - REQ: rd_req high, waiting for rd_ack.
  - WAIT: request accepted, waiting for rd_valid.
  - FULL: buf holds the next word.
  - DEAD: rest of the line is lost.
- Transitions:
  - IDLE -> REQ at CounterX = X0-16 when the row is in the window; rd_addr = {r, 5'd0}.
  - REQ -> WAIT on rd_ack.
  - WAIT -> FULL on rd_valid; buf <= rd_data.
  - At each group boundary (CounterX = X0+16g), in FULL: shreg <= buf. If g < 31, go to REQ with rd_addr = {r, g+1}; if g = 31, go to IDLE.
  - At a group boundary in REQ or WAIT (underrun): set underrun and go to DEAD. Group g and every later group on this line display ERR.
  - DEAD: a request still in REQ drops rd_req immediately (an rd_ack in the same cycle counts as accepted). An accepted-but-unreturned request discards its rd_valid. Go to IDLE once nothing is outstanding.
- rd_valid outside WAIT/DEAD-outstanding is ignored. rd_ack while rd_req = 0 is ignored.
- underrun clears at CounterX = 0 and CounterY = 0. If an underrun occurs in that same cycle, set wins.

## Timing
- Reset (async, rst_n = 0): pixel = 3'b000, rd_req = 0, rd_addr = 0, underrun = 0, buf = 0, shreg = 0, state IDLE.
- After rst_n deasserts, the first fetch starts at the next qualifying X0-16 point. A line already in progress stays BG.
- pixel has 1-cycle latency: pixel at cycle t+1 reflects CounterX/CounterY at cycle t, matching the existing registered pixel path.
- rd_req asserts the cycle after the FSM enters REQ. Earliest ack is the same cycle rd_req is seen high.
- Memory budget: ack plus data must complete within 16 cycles of the request. The first word of a line has exactly 16 cycles (X0-16 to X0).
- Exactly 32 reads per active row; zero reads on non-window rows.

## Test plan
- Reset: rst_n = 0 mid-line -> pixel = 0, rd_req = 0, underrun = 0 immediately; after release, the next row fetches from {r, 0}.
- Zero-wait memory (ack same cycle, valid next cycle), word 0x0001 at address 0 and 0 elsewhere:
  - Row Y0, CounterX = X0 -> pixel = FG one cycle later.
  - CounterX = X0+1..X0+511 -> BG.
  - 32 reads occur, addresses 0..31.
- Pattern 0xA5C3 at address {5, 7}: columns X0+112..X0+127 on row Y0+5 -> FG/BG sequence taken from bits 0..15 (1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1).
- Border: CounterY = Y0-1 or Y0+256, or CounterX < X0 or >= X0+512 -> pixel = BG and no rd_req. Last read of a row is {r, 31}.
- Underrun: delay rd_valid for group 10 beyond its boundary ->
  - underrun = 1.
  - Groups 10..31 show ERR.
  - Late data is discarded.
  - Next row is normal.
  - underrun clears at the next (0,0).
- Back-pressure: hold rd_ack low 5 cycles with rd_valid 3 cycles after ack -> rd_addr stays stable while rd_req is high; image is correct.
